// File: rtl/dvp_pixel_capture.sv
// DVP camera receiver: oversamples PCLK/VSYNC/HREF/D, pairs bytes into RGB565 pixels
// tagged with sof/eol, and buffers them in a first-word-fall-through valid/ready FIFO.
module dvp_pixel_capture #(
  parameter int unsigned DVP_CAM_CFG_W = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned FRM_CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DVP_CAM_CFG_W-1:0] dcr_cam_cfg_i,
  input  logic                     dvp_pclk_i,
  input  logic                     dvp_vsync_i,
  input  logic                     dvp_href_i,
  input  logic [7:0]               dvp_d_i,
  output logic [15:0]              m_pxl_data_o,
  output logic                     m_pxl_sof_o,
  output logic                     m_pxl_eol_o,
  output logic                     m_pxl_valid_o,
  input  logic                     m_pxl_ready_i,
  output logic                     stat_ovf_o,
  output logic                     stat_odd_o,
  output logic [FRM_CNT_W-1:0]     stat_frm_cnt_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSync  = 2'd1;
  localparam logic [1:0] StFrame = 2'd2;

  logic cam_start;
  logic unused_cfg;
  assign cam_start  = dcr_cam_cfg_i[7];
  assign unused_cfg = ^{dcr_cam_cfg_i[DVP_CAM_CFG_W-1:8], dcr_cam_cfg_i[6:0]};

  // pclk_q[2] is the previous value of the second sync stage, used for edge detection
  logic [2:0] pclk_q;
  logic [1:0] vsync_q, href_q;
  logic [7:0] d_s1_q, d_s2_q;
  logic       vsync_last_q, href_last_q;
  logic       pclk_rise, vsync_rise, vsync_fall, href_fall;

  assign pclk_rise  = pclk_q[1] & ~pclk_q[2];
  assign vsync_rise = pclk_rise & vsync_q[1] & ~vsync_last_q;
  assign vsync_fall = pclk_rise & ~vsync_q[1] & vsync_last_q;
  assign href_fall  = pclk_rise & ~href_q[1] & href_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_q       <= '0;
      vsync_q      <= '0;
      href_q       <= '0;
      d_s1_q       <= '0;
      d_s2_q       <= '0;
      vsync_last_q <= 1'b0;
      href_last_q  <= 1'b0;
    end else begin
      pclk_q  <= {pclk_q[1:0], dvp_pclk_i};
      vsync_q <= {vsync_q[0], dvp_vsync_i};
      href_q  <= {href_q[0], dvp_href_i};
      d_s1_q  <= dvp_d_i;
      d_s2_q  <= d_s1_q;
      if (pclk_rise) begin
        vsync_last_q <= vsync_q[1];
        href_last_q  <= href_q[1];
      end
    end
  end

  logic [1:0]           state_q, state_d;
  logic                 phase_q, phase_d;
  logic [7:0]           hi_byte_q, hi_byte_d;
  logic                 stage_vld_q, stage_vld_d;
  logic [15:0]          stage_q, stage_d;
  logic                 sof_pend_q, sof_pend_d;
  logic                 odd_q, odd_d;
  logic [FRM_CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic                 push_req, push_eol, flush;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_byte_d   = hi_byte_q;
    stage_vld_d = stage_vld_q;
    stage_d     = stage_q;
    sof_pend_d  = sof_pend_q;
    odd_d       = odd_q;
    frm_cnt_d   = frm_cnt_q;
    push_req    = 1'b0;
    push_eol    = 1'b0;
    flush       = 1'b0;
    if (!cam_start) begin
      state_d     = StIdle;
      phase_d     = 1'b0;
      stage_vld_d = 1'b0;
      sof_pend_d  = 1'b0;
      odd_d       = 1'b0;
      flush       = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSync;
        StSync: begin
          if (vsync_fall) begin
            state_d    = StFrame;
            sof_pend_d = 1'b1;
          end
        end
        StFrame: begin
          if (vsync_rise) begin
            phase_d     = 1'b0;
            stage_vld_d = 1'b0;
            frm_cnt_d   = frm_cnt_q + FRM_CNT_W'(1);
            state_d     = StSync;
          end else if (pclk_rise && href_q[1]) begin
            if (!phase_q) begin
              hi_byte_d = d_s2_q;
              phase_d   = 1'b1;
            end else begin
              // Previous pixel leaves the stage only once we know it is not the last of the line
              phase_d     = 1'b0;
              stage_d     = {hi_byte_q, d_s2_q};
              stage_vld_d = 1'b1;
              push_req    = stage_vld_q;
            end
          end else if (href_fall) begin
            push_req    = stage_vld_q;
            push_eol    = 1'b1;
            stage_vld_d = 1'b0;
            if (phase_q) begin
              odd_d   = 1'b1;
              phase_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (push_req) sof_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      hi_byte_q   <= '0;
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
      sof_pend_q  <= 1'b0;
      odd_q       <= 1'b0;
      frm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_byte_q   <= hi_byte_d;
      stage_vld_q <= stage_vld_d;
      stage_q     <= stage_d;
      sof_pend_q  <= sof_pend_d;
      odd_q       <= odd_d;
      frm_cnt_q   <= frm_cnt_d;
    end
  end

  // Entry layout: {sof, eol, pixel}
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          ovf_q, full, empty, pop, do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ~empty & m_pxl_ready_i;
  assign do_push = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {sof_pend_q, push_eol, stage_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_req && !do_push) ovf_q <= 1'b1;
    end
  end

  logic [17:0] head;
  assign head           = mem_q[rd_ptr_q[AW-1:0]];
  assign m_pxl_valid_o  = ~empty;
  assign m_pxl_data_o   = empty ? 16'h0 : head[15:0];
  assign m_pxl_eol_o    = ~empty & head[16];
  assign m_pxl_sof_o    = ~empty & head[17];
  assign stat_ovf_o     = ovf_q;
  assign stat_odd_o     = odd_q;
  assign stat_frm_cnt_o = frm_cnt_q;

endmodule
